// File: rtl/spi_slave_responder.sv
// SPI slave that answers exactly one frame per arm request: shifts out a word
// latched at arm time and captures the master's word, flagging bad bit counts.
module spi_slave_responder #(
    parameter int WID      = 18,
    parameter int WID_LEN  = 5,
    parameter bit POLARITY = 1'b1,
    parameter bit PHASE    = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sck,
    input  logic           ss,
    input  logic           mosi,
    output logic           miso,
    input  logic           arm,
    input  logic [WID-1:0] to_master,
    output logic [WID-1:0] from_master,
    output logic           finished,
    output logic           err
);

    typedef enum logic [2:0] {IDLE, WAIT_IDLE, WAIT_SS, SHIFT, DONE} state_t;

    state_t             state, state_next;
    logic [2:0]         sck_sync, ss_sync;
    logic [1:0]         mosi_sync;
    logic [1:0]         settle;
    logic [WID-1:0]     tx_sr, rx_sr, tx_shifted;
    logic [WID_LEN-1:0] bit_cnt;
    logic               overflow;
    logic               sck_chg, sck_lead, sck_trail, sample_edge, drive_edge;
    logic               ss_rise, ss_fall, cnt_full;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            settle    <= '0;
        end else begin
            sck_sync  <= {sck_sync[1:0], sck};
            ss_sync   <= {ss_sync[1:0], ss};
            mosi_sync <= {mosi_sync[0], mosi};
            settle    <= {settle[0], 1'b1};
        end
    end

    assign sck_chg     = sck_sync[1] ^ sck_sync[2];
    assign sck_lead    = sck_chg & (sck_sync[1] != POLARITY);
    assign sck_trail   = sck_chg & (sck_sync[1] == POLARITY);
    assign sample_edge = PHASE ? sck_trail : sck_lead;
    assign drive_edge  = PHASE ? sck_lead : sck_trail;
    assign ss_rise     = ss_sync[1] & ~ss_sync[2];
    assign ss_fall     = ~ss_sync[1] & ss_sync[2];
    assign cnt_full    = (bit_cnt == WID_LEN'(WID));
    assign tx_shifted  = {tx_sr[WID-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: default assigned first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            // Synchronizers restart from zero after reset; arming before they refill
            // would misread a still-high ss as low and join a frame already running.
            IDLE:      if (arm && settle[1]) state_next = WAIT_IDLE;
            WAIT_IDLE: if (!arm) state_next = IDLE;
                       else if (!ss_sync[1]) state_next = WAIT_SS;
            WAIT_SS:   if (!arm) state_next = IDLE;
                       else if (ss_rise) state_next = SHIFT;
            SHIFT:     if (!arm) state_next = IDLE;
                       else if (ss_fall) state_next = DONE;
            DONE:      if (!arm) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miso        <= 1'b0;
            finished    <= 1'b0;
            err         <= 1'b0;
            from_master <= '0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    miso     <= 1'b0;
                    finished <= 1'b0;
                    if (arm && settle[1]) begin
                        tx_sr    <= to_master;
                        rx_sr    <= '0;
                        bit_cnt  <= '0;
                        err      <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                WAIT_IDLE: miso <= 1'b0;
                WAIT_SS:   miso <= (arm && ss_rise && !PHASE) ? tx_sr[WID-1] : 1'b0;
                SHIFT: begin
                    // ss fall outranks a coincident sck edge, which is dropped.
                    if (!arm) begin
                        miso <= 1'b0;
                    end else if (ss_fall) begin
                        miso     <= 1'b0;
                        finished <= 1'b1;
                        if (cnt_full && !overflow) begin
                            from_master <= rx_sr;
                            err         <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (sample_edge) begin
                        if (cnt_full) begin
                            overflow <= 1'b1;
                        end else begin
                            rx_sr   <= {rx_sr[WID-2:0], mosi_sync[1]};
                            bit_cnt <= bit_cnt + WID_LEN'(1);
                        end
                    end else if (drive_edge) begin
                        tx_sr <= tx_shifted;
                        if (cnt_full)   miso <= 1'b0;
                        else if (PHASE) miso <= tx_sr[WID-1];
                        else            miso <= tx_shifted[WID-1];
                    end
                end
                DONE: begin
                    miso <= 1'b0;
                    if (!arm) finished <= 1'b0;
                end
                default: miso <= 1'b0;
            endcase
        end
    end

endmodule
